// File: rtl/reg_file_clr.sv
// reg_file_clr: 32 x WIDTH integer register file feeding the ALU operands.
// A clear engine sweeps x1..x31 after reset; ready rises once the sweep ends.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   a1, a2     combinational read addresses (rd1 -> ALU a, rd2 -> b mux)
//   a3, wd3    write address / data from writeback
//   we3        write enable (ignored while clearing, discarded for x0)
//   rd1, rd2   read data, forced to 0 until ready
//   ready      1 once the clear sweep is complete
module reg_file_clr #(
    parameter int                  WIDTH   = 32,
    parameter logic [WIDTH-1:0]    SP_INIT = 32'h0000_0FFC,
    parameter bit                  BYPASS  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       a1,
    input  logic [4:0]       a2,
    input  logic [4:0]       a3,
    input  logic [WIDTH-1:0] wd3,
    input  logic             we3,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             ready
);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]       state;
    logic [4:0]       idx;
    logic [WIDTH-1:0] regs [32];

    logic             wr_en;

    // x0 is never written; reads of x0 are forced to 0 below.
    assign wr_en = (state == S_RUN) && we3 && (a3 != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLEAR;
            idx   <= 5'd1;
            ready <= 1'b0;
        end else begin
            unique case (state)
                S_CLEAR: begin
                    idx <= idx + 5'd1;
                    if (idx == 5'd31) begin
                        state <= S_RUN;
                        ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    state <= S_RUN;
                end
                default: begin
                    state <= S_CLEAR;
                end
            endcase
        end
    end

    // Storage has no reset; the sweep gives every entry a defined value
    // before ready can expose it on the read ports.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR) begin
                regs[idx] <= (idx == 5'd2) ? SP_INIT : '0;
            end else if (wr_en) begin
                regs[a3] <= wd3;
            end
        end
    end

    // a != 0 together with a3 == a already excludes a write to x0.
    function automatic logic [WIDTH-1:0] read_port(input logic [4:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        if (ready && (a != 5'd0)) begin
            if (BYPASS && we3 && (a3 == a)) begin
                v = wd3;
            end else begin
                v = regs[a];
            end
        end
        return v;
    endfunction

    always_comb begin
        rd1 = read_port(a1);
        rd2 = read_port(a2);
    end

endmodule

// File: tb/tb_reg_file_clr.sv
// tb_reg_file_clr: scoreboard bench for reg_file_clr, both bypass variants.
// Stimulus pushes expected reads; a negedge monitor pops and compares.
module tb_reg_file_clr;

    localparam logic [31:0] SP = 32'h0000_0FFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        we3;
    logic [4:0]  a1, a2, a3;
    logic [31:0] wd3;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        rdy_b, rdy_n;

    always #5 clk = ~clk;

    reg_file_clr #(.WIDTH(32), .SP_INIT(SP), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst(rst), .a1(a1), .a2(a2), .a3(a3),
        .wd3(wd3), .we3(we3), .rd1(rd1_b), .rd2(rd2_b), .ready(rdy_b)
    );

    reg_file_clr #(.WIDTH(32), .SP_INIT(SP), .BYPASS(1'b0)) dut_nobyp (
        .clk(clk), .rst(rst), .a1(a1), .a2(a2), .a3(a3),
        .wd3(wd3), .we3(we3), .rd1(rd1_n), .rd2(rd2_n), .ready(rdy_n)
    );

    typedef struct {
        logic [31:0] r1b;
        logic [31:0] r2b;
        logic [31:0] r1n;
        logic [31:0] r2n;
        logic        rdy;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: architectural register contents plus a count of
    // reset-free edges; the file becomes visible after 31 such edges.
    logic [31:0] m_regs [32];
    int          m_cnt;
    bit          m_ready;

    function automatic logic [31:0] m_read(input bit byp, input logic [4:0] a);
        if (!m_ready || a == 5'd0) return 32'h0;
        if (byp && we3 && a3 == a) return wd3;
        return m_regs[a];
    endfunction

    task automatic model_edge(input bit r, input bit w,
                              input logic [4:0] x3, input logic [31:0] d);
        if (r) begin
            m_cnt   = 0;
            m_ready = 1'b0;
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == 31) begin
                m_ready = 1'b1;
                for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
                m_regs[2] = SP;
            end
        end else if (w && x3 != 5'd0) begin
            m_regs[x3] = d;
        end
    endtask

    task automatic step(input bit r, input logic [4:0] x1, input logic [4:0] x2,
                        input logic [4:0] x3, input logic [31:0] d, input bit w);
        exp_t e;
        rst = r; a1 = x1; a2 = x2; a3 = x3; wd3 = d; we3 = w;
        e.r1b = m_read(1'b1, x1);
        e.r2b = m_read(1'b1, x2);
        e.r1n = m_read(1'b0, x1);
        e.r2n = m_read(1'b0, x2);
        e.rdy = m_ready;
        sbq.push_back(e);
        @(posedge clk);
        model_edge(r, w, x3, d);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (a1=%0d a2=%0d a3=%0d we3=%b t=%0t)",
                     n, act, exp, a1, a2, a3, we3, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                vectors++;
                chk("ready_byp",   {31'b0, rdy_b}, {31'b0, e.rdy});
                chk("ready_nobyp", {31'b0, rdy_n}, {31'b0, e.rdy});
                chk("rd1_byp",   rd1_b, e.r1b);
                chk("rd2_byp",   rd2_b, e.r2b);
                chk("rd1_nobyp", rd1_n, e.r1n);
                chk("rd2_nobyp", rd2_n, e.r2n);
            end
        end
    end

    function automatic logic [4:0] raddr();
        return 5'($urandom_range(31, 0));
    endfunction

    initial begin
        logic [4:0]  x1, x2, x3;
        logic [31:0] d;
        bit          w, r;

        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        rst = 1'b1; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
        @(posedge clk);
        model_edge(1'b1, 1'b0, 5'd0, 32'h0);
        #1;

        // Reset state, then a sweep with a write to x9 held asserted.
        step(1'b1, 5'd2, 5'd5, 5'd9, 32'h1234_5678, 1'b1);
        for (int i = 0; i < 31; i++)
            step(1'b0, raddr(), raddr(), 5'd9, 32'h1234_5678, 1'b1);
        step(1'b0, 5'd2, 5'd5, 5'd0, 32'h0, 1'b0);
        step(1'b0, 5'd31, 5'd9, 5'd0, 32'h0, 1'b0);
        step(1'b0, 5'd9, 5'd2, 5'd0, 32'h0, 1'b0);

        // Same-cycle write/read of x7 on both variants, then readback.
        step(1'b0, 5'd7, 5'd7, 5'd7, 32'hDEAD_BEEF, 1'b1);
        step(1'b0, 5'd7, 5'd1, 5'd0, 32'h0, 1'b0);

        // Writes to x0 are discarded and never forwarded.
        step(1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);

        // Random traffic in RUN, biased toward read/write address hits.
        for (int i = 0; i < 300; i++) begin
            x3 = raddr();
            x1 = ($urandom_range(3, 0) == 0) ? x3 : raddr();
            x2 = ($urandom_range(3, 0) == 0) ? x3 : raddr();
            d  = $urandom;
            w  = ($urandom_range(1, 0) == 1);
            step(1'b0, x1, x2, x3, d, w);
        end

        // Write x3, then reset while the sweep sits at idx 10.
        step(1'b0, 5'd3, 5'd0, 5'd3, 32'h55, 1'b1);
        step(1'b0, 5'd3, 5'd2, 5'd0, 32'h0, 1'b0);
        step(1'b1, 5'd3, 5'd2, 5'd0, 32'h0, 1'b0);
        for (int i = 0; i < 9; i++)
            step(1'b0, 5'd3, 5'd2, 5'd3, 32'hAAAA_AAAA, 1'b1);
        step(1'b1, 5'd3, 5'd2, 5'd0, 32'h0, 1'b0);
        for (int i = 0; i < 31; i++)
            step(1'b0, raddr(), raddr(), raddr(), $urandom, 1'b1);
        step(1'b0, 5'd3, 5'd2, 5'd0, 32'h0, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(99, 0) == 0);
            x3 = raddr();
            x1 = ($urandom_range(2, 0) == 0) ? x3 : raddr();
            x2 = ($urandom_range(2, 0) == 0) ? x3 : raddr();
            d  = $urandom;
            w  = ($urandom_range(1, 0) == 1);
            step(r, x1, x2, x3, d, w);
        end

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_file_clr.md
Name: reg_file_clr

Overview:
- 32-entry x WIDTH-bit RISC-V integer register file that sits directly upstream of the ALU. rd1 drives ALU operand a; rd2 drives the b operand mux.
- Write port is fed from writeback (ALU result / load data).
- After reset, a sequential clear engine initialises every register before the core is released. Optional write-first bypass lets a same-cycle writeback be seen on the read ports.

Parameters:
WIDTH, 32, data width of every register and port
SP_INIT, 32'h0000_0FFC, value loaded into x2 (sp) by the clear engine; all other registers clear to 0
BYPASS, 1, 1 = write-first forwarding of wd3 onto rd1/rd2; 0 = read returns pre-write value

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
a1  input  5  read address port 1
a2  input  5  read address port 2
a3  input  5  write address
wd3  input  WIDTH  write data
we3  input  1  write enable
rd1  output  WIDTH  read data port 1 (to ALU a)
rd2  output  WIDTH  read data port 2 (to ALU b mux)
ready  output  1  1 = clear complete, register file usable

Behaviour:
- One clock. Reset is synchronous and active-high. clk and rst are the only timing inputs.
- State machine: CLEAR and RUN. A 5-bit index counter idx is used only in CLEAR.
- rst=1 at a rising edge, from any state (including mid-CLEAR or RUN): state<=CLEAR, idx<=1, ready<=0. Holding rst keeps idx at 1. A reset mid-clear restarts the sweep from 1.
- CLEAR, rst=0, each edge:
  - Writes reg[idx] with SP_INIT if idx==2, else 0; then idx<=idx+1.
  - On the edge that writes idx==31: state<=RUN and ready<=1.
  - ready therefore rises on the 31st rst-low edge after reset release.
- ready is registered. Reset value is 0. It is 1 only in RUN.
- Writes are ignored in CLEAR: we3, a3 and wd3 are don't-care.
- RUN writes: at the rising edge, if we3==1 and a3!=0, reg[a3]<=wd3. A write to x0 is discarded.
- Reads are combinational (zero-cycle latency) from a1/a2:
  - ready==0: rd1=rd2=0.
  - a==0: result is 0 regardless of bypass or any attempted write.
  - BYPASS=1 and ready==1 and we3==1 and a3==a1 and a3!=0: rd1=wd3. Same rule for rd2 with a2.
  - Otherwise rdN=reg[aN].
- Both ports may read the same address, and both may match the write address, in the same cycle; each port is resolved independently.
- x0 storage holds no state; it always reads as 0.
- Register contents persist in RUN until overwritten. Only rst re-enters CLEAR.
- No X may propagate to rd1/rd2 after reset, even if registers had no power-up value.

Test Plan:
- Reset sweep: hold rst 2 cycles, release.
  - ready=0 for exactly 30 edges and goes 1 on edge 31.
  - Then read a1=2 -> rd1=0x00000FFC; a2=5 -> rd2=0; a1=31 -> rd1=0.
- Write/read with BYPASS=1 (RUN): we3=1, a3=7, wd3=0xDEADBEEF, a1=7 in the same cycle.
  - rd1=0xDEADBEEF before the edge.
  - After the edge, with we3=0: rd1=0xDEADBEEF.
- Same stimulus with BYPASS=0.
  - rd1 = old value (0) before the edge.
  - rd1 = 0xDEADBEEF after the edge.
- x0 protection: we3=1, a3=0, wd3=0xFFFFFFFF, a1=a2=0.
  - rd1=rd2=0 in the write cycle and in every following cycle.
- Writes blocked in CLEAR: assert we3=1, a3=9, wd3=0x12345678 throughout the sweep.
  - After ready=1, a1=9 -> rd1=0.
- Reset mid-operation: write x3=0x55 in RUN, then rst=1 for 1 cycle at sweep idx=10, then release.
  - ready stays 0 for another 31 edges.
  - Afterwards x3 reads 0 and x2 reads 0xFFC.
